// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 receiver with byte FIFO, timeout and sticky errors (optional odd parity check: PS2_RX_PARITY_EN)
module ps2_rx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int TIMEOUT    = 2500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  done,
   input  logic                  clr_err,
   input  logic                  PS2C,
   input  logic                  PS2D,
   output logic                  rdy,
   output logic [7:0]            data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  shift,
   output logic                  ovf,
   output logic                  perr,
   output logic                  ferr
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic                  r_q0;
   logic                  r_q1;
   logic [10:0]           r_shreg;
   logic [15:0]           r_tcnt;
   logic [DEPTH_LOG2-1:0] r_wptr;
   logic [DEPTH_LOG2-1:0] r_rptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_ovf;
   logic                  r_ferr;
   logic [7:0]            r_mem [DEPTH];

   logic w_shift;
   logic w_complete;
   logic w_idle;
   logic w_timeout;
   logic w_stop_ok;
   logic w_par_ok;
   logic w_wr;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_ovf_set;
   logic w_ferr_set;

   // The start bit (always 0) lands in bit 0 exactly when all 11 bits are in,
   // because the register is preset to all-ones between frames.
   assign w_shift    = r_q1 & ~r_q0;
   assign w_complete = ~r_shreg[0];
   assign w_idle     = &r_shreg;
   assign w_timeout  = ~w_idle & ~w_complete & (r_tcnt == 16'(TIMEOUT));
   assign w_stop_ok  = r_shreg[10];

`ifdef PS2_RX_PARITY_EN
   logic r_perr;
   logic w_perr_set;
   assign w_par_ok   = ^r_shreg[9:1];
   assign w_perr_set = w_complete & w_stop_ok & ~w_par_ok;
   assign perr       = r_perr;

   // Sticky parity error; a same-cycle set wins over clr_err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perr <= 1'b0;
      end else if (enable) begin
         if (w_perr_set)   r_perr <= 1'b1;
         else if (clr_err) r_perr <= 1'b0;
      end
   end
`else
   assign w_par_ok = 1'b1;
   assign perr     = 1'b0;
`endif

   assign w_wr       = w_complete & w_stop_ok & w_par_ok;
   assign w_full     = (r_count == FULL_CNT);
   assign w_pop      = done & rdy;
   assign w_push     = w_wr & (~w_full | w_pop);
   assign w_ovf_set  = w_wr & w_full & ~w_pop;
   assign w_ferr_set = (w_complete & ~w_stop_ok) | w_timeout;

   assign shift = w_shift;
   assign rdy   = (r_count != '0);
   assign count = r_count;
   assign data  = r_mem[r_rptr];
   assign ovf   = r_ovf;
   assign ferr  = r_ferr;

   // PS2C synchroniser; idles high so no false edge leaves reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q0 <= 1'b1;
         r_q1 <= 1'b1;
      end else if (enable) begin
         r_q0 <= PS2C;
         r_q1 <= r_q0;
      end
   end

   // Frame shift register: preset after a completed or timed-out frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shreg <= '1;
      end else if (enable) begin
         if (w_complete || w_timeout) r_shreg <= '1;
         else if (w_shift)            r_shreg <= {PS2D, r_shreg[10:1]};
      end
   end

   // Inactivity counter, runs only while a partial frame is held
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt <= '0;
      end else if (enable) begin
         if (w_shift || w_complete || w_timeout) r_tcnt <= '0;
         else if (!w_idle && r_tcnt != 16'hFFFF) r_tcnt <= r_tcnt + 16'd1;
      end
   end

   // FIFO storage, not reset
   always_ff @(posedge clk) begin
      if (enable && w_push) r_mem[r_wptr] <= r_shreg[8:1];
   end

   // FIFO pointers and occupancy; push and pop together leave count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (enable) begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
   end

   // Sticky overflow and framing errors; a same-cycle set wins over clr_err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf  <= 1'b0;
         r_ferr <= 1'b0;
      end else if (enable) begin
         if (w_ovf_set)    r_ovf <= 1'b1;
         else if (clr_err) r_ovf <= 1'b0;
         if (w_ferr_set)   r_ferr <= 1'b1;
         else if (clr_err) r_ferr <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

   localparam int DL2     = 4;
   localparam int TIMEOUT = 200;

   logic           clk = 1'b0;
   logic           rst;
   logic           enable;
   logic           done;
   logic           clr_err;
   logic           PS2C;
   logic           PS2D;
   logic           rdy;
   logic [7:0]     data;
   logic [DL2:0]   count;
   logic           shift;
   logic           ovf;
   logic           perr;
   logic           ferr;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   ps2_rx_fifo #(.DEPTH_LOG2(DL2), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .enable(enable), .done(done), .clr_err(clr_err),
      .PS2C(PS2C), .PS2D(PS2D), .rdy(rdy), .data(data), .count(count),
      .shift(shift), .ovf(ovf), .perr(perr), .ferr(ferr)
   );

   always #20 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pop_exp();
      if (exp_q.size() == 0) return 8'hxx;
      return exp_q.pop_front();
   endfunction

   // n bits LSB first; optionally pulse done in the cycle the frame completes
   task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_last);
      for (int i = 0; i < n; i++) begin
         PS2D = bits[i];
         tick(); tick();
         PS2C = 1'b0;
         tick(); tick();
         if (pop_last && i == n - 1) begin
            check("pop_head", {24'd0, data}, {24'd0, pop_exp()});
            done = 1'b1;
         end
         tick();
         done = 1'b0;
         tick();
         PS2C = 1'b1;
         tick(); tick();
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit good_par, input bit stop, input bit pop_last);
      logic [10:0] v;
      v = {stop, (good_par ? ~^b : ^b), b, 1'b0};
      send_bits(v, 11, pop_last);
      repeat (4) tick();
   endtask

   task automatic read_one(input string tag);
      check({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
      check(tag, {24'd0, data}, {24'd0, pop_exp()});
      done = 1'b1;
      tick();
      done = 1'b0;
      check({tag, "_cnt"}, {27'd0, count}, exp_q.size());
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; done = 1'b0; clr_err = 1'b0; PS2C = 1'b1; PS2D = 1'b1;
      tick(); tick();
      check("rst_rdy",   {31'd0, rdy},   32'd0);
      check("rst_count", {27'd0, count}, 32'd0);
      check("rst_shift", {31'd0, shift}, 32'd0);
      check("rst_errs",  {29'd0, ovf, perr, ferr}, 32'd0);
      rst = 1'b0;
      tick();

      // Single byte, then empty-FIFO done is ignored
      send_frame(8'h1C, 1, 1, 0);
      exp_q.push_back(8'h1C);
      check("one_count", {27'd0, count}, 32'd1);
      read_one("one_data");
      check("one_rdy0", {31'd0, rdy}, 32'd0);
      done = 1'b1; tick(); done = 1'b0;
      check("empty_done", {27'd0, count}, 32'd0);

      // Fill and overflow
      for (int i = 0; i <= 16; i++) begin
         send_frame(8'(i), 1, 1, 0);
         if (exp_q.size() < 16) exp_q.push_back(8'(i));
      end
      check("full_count", {27'd0, count}, 32'd16);
      check("full_ovf",   {31'd0, ovf},   32'd1);
      pulse_clr();
      check("ovf_clr",    {31'd0, ovf},   32'd0);

      // Write and pop in the same cycle while full
      send_frame(8'h77, 1, 1, 1);
      exp_q.push_back(8'h77);
      check("wrpop_count", {27'd0, count}, 32'd16);
      check("wrpop_ovf",   {31'd0, ovf},   32'd0);
      for (int i = 0; i < 16; i++) read_one("drain");

      // Wrong parity byte
      send_frame(8'h55, 0, 1, 0);
`ifdef PS2_RX_PARITY_EN
      check("par_perr",  {31'd0, perr},  32'd1);
      check("par_count", {27'd0, count}, 32'd0);
      pulse_clr();
      check("par_clr",   {31'd0, perr},  32'd0);
`else
      exp_q.push_back(8'h55);
      check("par_perr0", {31'd0, perr},  32'd0);
      read_one("par_ignored");
`endif

      // Bad stop bit
      send_frame(8'h3C, 1, 0, 0);
      check("stop_ferr",  {31'd0, ferr},  32'd1);
      check("stop_count", {27'd0, count}, 32'd0);
      pulse_clr();
      check("stop_clr",   {31'd0, ferr},  32'd0);

      // Partial frame then inactivity timeout
      send_bits(11'h7E0, 5, 0);
      repeat (TIMEOUT / 2) tick();
      check("to_early", {31'd0, ferr}, 32'd0);
      repeat (TIMEOUT / 2 + 1) tick();
      check("to_ferr",  {31'd0, ferr},  32'd1);
      check("to_count", {27'd0, count}, 32'd0);
      pulse_clr();
      send_frame(8'hAA, 1, 1, 0);
      exp_q.push_back(8'hAA);
      read_one("to_next");

      // Reset mid-frame
      send_bits(11'h7D4, 6, 0);
      rst = 1'b1;
      #1;
      check("mrst_shreg", {21'd0, dut.r_shreg}, 32'h7FF);
      check("mrst_rdy",   {31'd0, rdy},         32'd0);
      tick();
      rst = 1'b0;
      tick();
      send_frame(8'h3A, 1, 1, 0);
      exp_q.push_back(8'h3A);
      read_one("mrst_next");

      // Clock enable low freezes the pop
      send_frame(8'h5A, 1, 1, 0);
      exp_q.push_back(8'h5A);
      enable = 1'b0;
      done   = 1'b1;
      repeat (3) tick();
      done   = 1'b0;
      check("freeze_count", {27'd0, count}, 32'd1);
      enable = 1'b1;
      read_one("freeze_data");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes, legal range 1..8.
REQ-002 SHALL have parameter TIMEOUT, default 2500, enabled-cycle count of PS2C inactivity that aborts a partial frame, legal range 16..65535.
REQ-003 SHALL have ports, one per line:
 clk  in  1  system clock, 25 MHz
 rst  in  1  asynchronous reset, active-high
 enable  in  1  clock enable; all state frozen when 0
 done  in  1  consumer has read head byte
 clr_err  in  1  clears sticky error flags
 PS2C  in  1  PS/2 clock, asynchronous
 PS2D  in  1  PS/2 data
 rdy  out  1  FIFO non-empty
 data  out  8  head byte of FIFO
 count  out  DEPTH_LOG2+1  bytes held
 shift  out  1  falling-edge strobe on PS2C
 ovf  out  1  sticky overflow
 perr  out  1  sticky parity error
 ferr  out  1  sticky framing/timeout error

Function
REQ-004 SHALL sample PS2C through two flops Q0->Q1 on enabled cycles; shift = Q1 & ~Q0, combinational.
REQ-005 SHALL hold an 11-bit shift register, preset to all-ones; on shift, shift in PS2D at bit 10, right-shift.
REQ-006 Frame complete SHALL be shreg[0]==0 (start bit at bit 0); next enabled cycle shreg SHALL preset to all-ones.
REQ-007 On frame complete: data byte = shreg[8:1], parity = shreg[9], stop = shreg[10].
REQ-008 stop==0 SHALL discard byte and set ferr.
REQ-009 Valid byte SHALL be written at write pointer in the completing cycle; rdy/count/data reflect it on the next enabled cycle (1-cycle latency).
REQ-010 data SHALL be combinational read of entry at read pointer; undefined content while rdy=0 is permitted.
REQ-011 done with rdy=1 SHALL advance read pointer by 1; done with rdy=0 SHALL be ignored.
REQ-012 Pointers SHALL be DEPTH_LOG2 bits wrapping modulo depth; count SHALL range 0..2**DEPTH_LOG2.
REQ-013 Write when count==depth and no same-cycle pop SHALL drop byte, set ovf, leave FIFO unchanged.
REQ-014 Simultaneous write and pop when full SHALL both succeed, count unchanged, ovf not set.
REQ-015 Simultaneous write and pop when non-full SHALL both succeed, count unchanged.
REQ-016 Timeout counter SHALL clear on shift or frame complete, increment on enabled cycles while shreg != all-ones, saturate.
REQ-017 Counter reaching TIMEOUT SHALL preset shreg to all-ones and set ferr; no byte written.
REQ-018 clr_err SHALL clear ovf, perr, ferr; same-cycle set SHALL take priority over clear.
REQ-019 All registered state changes SHALL occur only on cycles with enable=1.

Reset
REQ-020 rst=1 SHALL asynchronously force: Q0=Q1=1, shreg=all-ones, pointers=0, count=0, timeout counter=0, ovf=perr=ferr=0.
REQ-021 During reset outputs SHALL be rdy=0, count=0, shift=0; FIFO storage need not reset.
REQ-022 Reset mid-frame SHALL discard the partial frame; reception restarts at next start bit after release.

Configuration
REQ-023 Macro PS2_RX_PARITY_EN defined: odd parity check over shreg[9:1]; failure SHALL discard byte and set perr.
REQ-024 Macro undefined: parity bit ignored, perr tied 0, no parity logic synthesised.

Verification
REQ-025 Send 0x1C, odd parity, stop=1 -> rdy=1, data=0x1C, count=1; pulse done -> rdy=0, count=0.
REQ-026 Send 17 bytes 0x00..0x10 with DEPTH_LOG2=4, no done -> count=16, ovf=1, reads return 0x00..0x0F in order.
REQ-027 With PS2_RX_PARITY_EN, send 0x55 with even parity -> perr=1, count=0; clr_err -> perr=0.
REQ-028 Send 5 bits then idle TIMEOUT+1 enabled cycles -> ferr=1, count=0; next full frame 0xAA received correctly.
REQ-029 FIFO full, frame completes same cycle as done -> count stays 16, ovf=0, new byte last in order.
REQ-030 Assert rst mid-frame after 6 bits -> rdy=0, shreg all-ones immediately; subsequent frame 0x3A received correctly.
